// File: rtl/reg_file_if.sv
// Bus between the datapath (master) and the parametrised register file (slave).
// Carries the write port, the read ports and the clear-sweep handshake.
interface reg_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                       clear_req;
   logic                       ready;
   logic                       we;
   logic [ADDR_W-1:0]          Rd;
   logic [DATA_W-1:0]          data_in;
   logic                       wr_err;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;

   modport master (
      output clear_req, we, Rd, data_in, rd_addr,
      input  ready, wr_err, rd_data
   );

   modport slave (
      input  clear_req, we, Rd, data_in, rd_addr,
      output ready, wr_err, rd_data
   );
endinterface

// File: rtl/reg_file_param.sv
// Parametrised multi-read-port register file with optional zero entry, write bypass,
// registered reads and a sequential clear sweep that gates the ready flag.
module reg_file_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1,
   parameter bit READ_REG = 1'b0
) (
   input  logic       clk_i,
   input  logic       rst_i,
   reg_file_if.slave  bus
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic {SWEEP, RUN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     idx_q, idx_d;
   logic                wrErr_q;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic                ready;
   logic                writeOk;

   assign ready    = (state_q == RUN);
   assign writeOk  = ready && bus.we && !(ZERO_REG && (bus.Rd == '0));
   assign bus.ready  = ready;
   assign bus.wr_err = wrErr_q;

   // idx carries one extra bit so reaching DEPTH marks the end of the sweep
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      case (state_q)
         SWEEP: begin
            idx_d = idx_q + (ADDR_W+1)'(1);
            if (idx_d == (ADDR_W+1)'(DEPTH)) begin
               state_d = RUN;
               idx_d   = '0;
            end
         end
         RUN: begin
            if (bus.clear_req) begin
               state_d = SWEEP;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = SWEEP;
            idx_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= SWEEP;
         idx_q   <= '0;
         wrErr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wrErr_q <= (state_q == SWEEP) && bus.we;
      end
   end

   // A write accepted together with clear_req commits here and is wiped by the sweep
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state_q == SWEEP) begin
            mem_q[idx_q[ADDR_W-1:0]] <= '0;
         end else if (writeOk) begin
            mem_q[bus.Rd] <= bus.data_in;
         end
      end
   end

   for (genvar g = 0; g < NUM_RD; g++) begin : gRd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] sel;

      assign addr = bus.rd_addr[g*ADDR_W +: ADDR_W];

      always_comb begin
         sel = '0;
         if (ready && !(ZERO_REG && (addr == '0))) begin
            if (BYPASS && writeOk && (bus.Rd == addr)) begin
               sel = bus.data_in;
            end else begin
               sel = mem_q[addr];
            end
         end
      end

      if (READ_REG) begin : gReg
         logic [DATA_W-1:0] rdData_q;

         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               rdData_q <= '0;
            end else begin
               rdData_q <= sel;
            end
         end

         assign bus.rd_data[g*DATA_W +: DATA_W] = rdData_q;
      end else begin : gComb
         assign bus.rd_data[g*DATA_W +: DATA_W] = sel;
      end
   end

endmodule

// File: tb/tb_reg_file_param.sv
// Randomised bench for reg_file_param: two instances (default and ZERO_REG=0/BYPASS=0/READ_REG=1)
// checked every cycle against a behavioural model, plus hand-computed literal checks.
module tb_reg_file_param;

   logic clk;
   logic rst;
   int   vectors = 0;
   int   miscompares = 0;

   reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifA ();
   reg_file_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifB ();

   reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                    .ZERO_REG(1'b1), .BYPASS(1'b1), .READ_REG(1'b0))
      dutA (.clk_i(clk), .rst_i(rst), .bus(ifA.slave));

   reg_file_param #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2),
                    .ZERO_REG(1'b0), .BYPASS(1'b0), .READ_REG(1'b1))
      dutB (.clk_i(clk), .rst_i(rst), .bus(ifB.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: sweepLeft counts remaining sweep cycles; storage reads as all-zero once a sweep starts
   int          sweepLeft = 32;
   bit          modelValid = 1'b0;
   bit          mdlErr = 1'b0;
   logic [31:0] memA [32];
   logic [31:0] memB [32];
   logic [31:0] expB [2];

   function automatic logic [31:0] modelRead(bit isA, logic [4:0] a);
      if (sweepLeft != 0) return 32'h0;
      if (isA && a == 5'd0) return 32'h0;
      if (isA && ifA.we && ifA.Rd == a) return ifA.data_in;
      return isA ? memA[a] : memB[a];
   endfunction

   task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int p = 0; p < 2; p++)
         expB[p] = rst ? 32'h0 : modelRead(1'b0, ifB.rd_addr[p*5 +: 5]);
      if (rst) begin
         sweepLeft = 32;
         mdlErr = 1'b0;
         modelValid = 1'b1;
         for (int i = 0; i < 32; i++) begin memA[i] = 32'h0; memB[i] = 32'h0; end
      end else if (sweepLeft > 0) begin
         sweepLeft--;
         mdlErr = ifA.we;
      end else begin
         mdlErr = 1'b0;
         if (ifA.we) begin
            if (ifA.Rd != 5'd0) memA[ifA.Rd] = ifA.data_in;
            memB[ifA.Rd] = ifA.data_in;
         end
         if (ifA.clear_req) begin
            sweepLeft = 32;
            for (int i = 0; i < 32; i++) begin memA[i] = 32'h0; memB[i] = 32'h0; end
         end
      end
   end

   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("readyA", 32'(ifA.ready), 32'(sweepLeft == 0));
         checkOutput("readyB", 32'(ifB.ready), 32'(sweepLeft == 0));
         checkOutput("wrErrA", 32'(ifA.wr_err), 32'(mdlErr));
         checkOutput("wrErrB", 32'(ifB.wr_err), 32'(mdlErr));
         for (int p = 0; p < 2; p++) begin
            checkOutput($sformatf("rdA%0d", p), ifA.rd_data[p*32 +: 32],
                        modelRead(1'b1, ifA.rd_addr[p*5 +: 5]));
            checkOutput($sformatf("rdB%0d", p), ifB.rd_data[p*32 +: 32], expB[p]);
         end
      end
   end

   task automatic applyStimulus(bit r, bit clr, bit w, logic [4:0] rd, logic [31:0] d,
                                logic [4:0] a0, logic [4:0] a1);
      rst = r;
      ifA.clear_req = clr; ifB.clear_req = clr;
      ifA.we = w;          ifB.we = w;
      ifA.Rd = rd;         ifB.Rd = rd;
      ifA.data_in = d;     ifB.data_in = d;
      ifA.rd_addr = {a1, a0};
      ifB.rd_addr = {a1, a0};
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic countNotReady(string name, int expCycles, int errAt);
      int cnt = 0;
      while (!ifA.ready && cnt < 100) begin
         applyStimulus(1'b0, 1'b0, cnt == errAt, 5'd9, 32'h55AA55AA, 5'd9, 5'd0);
         tick();
         cnt++;
         if (errAt >= 0 && cnt == errAt + 1) checkOutput("wrErrSweep", 32'(ifA.wr_err), 32'h1);
      end
      checkOutput(name, cnt, expCycles);
   endtask

   initial begin
      logic [4:0] r5;
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      checkOutput("readyAfterRst", 32'(ifA.ready), 32'h0);
      countNotReady("resetSweepLen", 32, -1);

      applyStimulus(1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      #1;
      checkOutput("wrRdA0", ifA.rd_data[31:0], 32'hDEADBEEF);
      checkOutput("wrRdA1", ifA.rd_data[63:32], 32'hDEADBEEF);
      tick();
      checkOutput("wrRdB0", ifB.rd_data[31:0], 32'hDEADBEEF);

      applyStimulus(1'b0, 1'b0, 1'b1, 5'd0, 32'h1234, 5'd3, 5'd3);
      tick();
      checkOutput("zeroWrErr", 32'(ifA.wr_err), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #1;
      checkOutput("zeroRegA", ifA.rd_data[31:0], 32'h0);
      tick();
      checkOutput("zeroRegOffB", ifB.rd_data[31:0], 32'h1234);

      applyStimulus(1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd3);
      #1;
      checkOutput("bypassA", ifA.rd_data[31:0], 32'hA5A5A5A5);
      tick();
      checkOutput("noBypassB", ifB.rd_data[31:0], 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd3);
      tick();
      checkOutput("regReadB", ifB.rd_data[31:0], 32'hA5A5A5A5);

      for (int i = 1; i < 32; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 5'(i), $urandom, 5'(i), 5'(32 - i));
         tick();
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd4, 5'd8);
      tick();
      checkOutput("readyDropClear", 32'(ifA.ready), 32'h0);
      countNotReady("clearSweepLen", 32, 3);
      for (int i = 0; i < 32; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
         #1;
         checkOutput("clearedA", ifA.rd_data[31:0], 32'h0);
         tick();
      end

      applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
         tick();
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      countNotReady("midSweepRstLen", 32, -1);

      for (int c = 0; c < 800; c++) begin
         r5 = 5'($urandom);
         applyStimulus($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
                       1'($urandom), r5, $urandom,
                       ($urandom_range(0, 3) == 0) ? r5 : 5'($urandom),
                       ($urandom_range(0, 3) == 0) ? r5 : 5'($urandom));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
